sensor_capture_seq: RTL and testbench

//  Parametrised line-sensor capture sequencer; successor to the fixed 50/15/512 exposure-readout timer.

---
 rtl/sensor_capture_seq_pkg.sv | 34 +++
 rtl/sensor_phase_timer.sv | 28 ++
 rtl/sensor_capture_seq.sv | 133 +++++++++++++
 tb/tb_sensor_capture_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_capture_seq_pkg.sv
// Shared definitions for the line-sensor capture sequencer: state encoding,
// width helpers and the default geometry used by the pixel RAM and host decoder.
package sensor_capture_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPOSE = 2'd1,
        S_DELAY  = 2'd2,
        S_READ   = 2'd3
    } state_t;

    localparam int DEF_PIX_COUNT = 512;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_DELAY     = 15;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sensor_phase_timer.sv
// Loadable down-counter that times one sequencer phase; done is high while
// the count sits at zero, which marks the last clock of the current phase.
module sensor_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Load wins over counting; the count parks at zero until the next load.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sensor_capture_seq.sv
// Line-sensor capture sequencer: exposure gate, readout delay, then one pixel
// address per clock. Supports single-shot and continuous capture, abort and a
// completed-frame counter. Every output comes straight from a flop.
module sensor_capture_seq
    import sensor_capture_seq_pkg::*;
#(
    parameter int PIX_COUNT = DEF_PIX_COUNT,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int EXPOS_W   = 16,
    parameter int DELAY     = DEF_DELAY,
    parameter int FRAME_W   = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start_capture,
    input  logic               abort,
    input  logic               cont_mode,
    input  logic [EXPOS_W-1:0] expos_len,
    output logic               sensor_expos,
    output logic               data_valid,
    output logic [ADDR_W-1:0]  data_adress,
    output logic               capture_complete,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt
);

    // One shared phase counter wide enough for exposure, delay and readout.
    localparam int CNT_W = max3(EXPOS_W, clog2(DELAY + 1), ADDR_W);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(PIX_COUNT - 1);

    state_t             state;
    state_t             state_next;
    logic               timer_load;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_val;
    logic [CNT_W-1:0]   expos_load;
    logic [ADDR_W-1:0]  addr_next;
    logic               complete_next;
    logic [FRAME_W-1:0] frame_next;

    // A zero exposure request is treated as one clock, so the load is L-1.
    assign expos_load = (expos_len == '0) ? '0 : CNT_W'(expos_len - EXPOS_W'(1));

    sensor_phase_timer #(
        .W(CNT_W)
    ) u_phase_timer (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Next-state, timer load and counter updates; abort always beats the other transitions.
    always_comb begin
        state_next    = state;
        timer_load    = 1'b0;
        timer_val     = '0;
        addr_next     = '0;
        complete_next = 1'b0;
        frame_next    = frame_cnt;
        case (state)
            S_IDLE: begin
                if (start_capture && !abort) begin
                    state_next = S_EXPOSE;
                    timer_load = 1'b1;
                    timer_val  = expos_load;
                end
            end
            S_EXPOSE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (timer_done) begin
                    state_next = S_DELAY;
                    timer_load = 1'b1;
                    timer_val  = DELAY_LOAD;
                end
            end
            S_DELAY: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (timer_done) begin
                    state_next = S_READ;
                    timer_load = 1'b1;
                    timer_val  = READ_LOAD;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (timer_done) begin
                    complete_next = 1'b1;
                    frame_next    = frame_cnt + FRAME_W'(1);
                    if (cont_mode) begin
                        state_next = S_EXPOSE;
                        timer_load = 1'b1;
                        timer_val  = expos_load;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    addr_next = data_adress + ADDR_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state            <= S_IDLE;
            sensor_expos     <= 1'b0;
            data_valid       <= 1'b0;
            data_adress      <= '0;
            capture_complete <= 1'b0;
            busy             <= 1'b0;
            frame_cnt        <= '0;
        end else begin
            state            <= state_next;
            sensor_expos     <= (state_next == S_EXPOSE);
            data_valid       <= (state_next == S_READ);
            data_adress      <= addr_next;
            capture_complete <= complete_next;
            busy             <= (state_next != S_IDLE);
            frame_cnt        <= frame_next;
        end
    end

endmodule

// File: tb/tb_sensor_capture_seq.sv
// Testbench for sensor_capture_seq: table vectors for single shots, hand-written
// corner sequences, randomized traffic against a frame-schedule model, and one
// default-parameter instance for the full-size cycle length.
module tb_sensor_capture_seq;

    localparam int P  = 8;
    localparam int D  = 3;
    localparam int AW = 3;
    localparam int EW = 16;
    localparam int FW = 16;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          start_capture = 1'b0;
    logic          abort = 1'b0;
    logic          cont_mode = 1'b0;
    logic [EW-1:0] expos_len = '0;
    logic          sensor_expos;
    logic          data_valid;
    logic [AW-1:0] data_adress;
    logic          capture_complete;
    logic          busy;
    logic [FW-1:0] frame_cnt;

    logic          d_start = 1'b0;
    logic          d_abort = 1'b0;
    logic          d_cont = 1'b0;
    logic [15:0]   d_expos = '0;
    logic          d_sensor_expos;
    logic          d_data_valid;
    logic [8:0]    d_data_adress;
    logic          d_capture_complete;
    logic          d_busy;
    logic [15:0]   d_frame_cnt;

    sensor_capture_seq #(
        .PIX_COUNT(P), .ADDR_W(AW), .EXPOS_W(EW), .DELAY(D), .FRAME_W(FW)
    ) dut (
        .clk_in           (clk_in),
        .rst              (rst),
        .start_capture    (start_capture),
        .abort            (abort),
        .cont_mode        (cont_mode),
        .expos_len        (expos_len),
        .sensor_expos     (sensor_expos),
        .data_valid       (data_valid),
        .data_adress      (data_adress),
        .capture_complete (capture_complete),
        .busy             (busy),
        .frame_cnt        (frame_cnt)
    );

    sensor_capture_seq dut_def (
        .clk_in           (clk_in),
        .rst              (rst),
        .start_capture    (d_start),
        .abort            (d_abort),
        .cont_mode        (d_cont),
        .expos_len        (d_expos),
        .sensor_expos     (d_sensor_expos),
        .data_valid       (d_data_valid),
        .data_adress      (d_data_adress),
        .capture_complete (d_capture_complete),
        .busy             (d_busy),
        .frame_cnt        (d_frame_cnt)
    );

    // Free-running 10-unit clock.
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: a frame is described by the edge it started on and its exposure.
    bit m_active = 1'b0;
    int m_n0 = 0;
    int m_L = 1;
    int m_frames = 0;
    bit m_complete = 1'b0;
    int edge_idx = 0;

    typedef struct {
        logic        start;
        logic [15:0] expos;
        logic        e_expos;
        logic        e_valid;
        logic [2:0]  e_addr;
        logic        e_complete;
        logic        e_busy;
        logic [15:0] e_frame;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_edge(input logic st, input logic ab, input logic co,
                              input logic [15:0] ex, input logic rs);
        m_complete = 1'b0;
        if (rs) begin
            m_active = 1'b0;
            m_frames = 0;
        end else if (m_active) begin
            if (ab) begin
                m_active = 1'b0;
            end else if (edge_idx == m_n0 + m_L + D + P) begin
                m_complete = 1'b1;
                m_frames = (m_frames + 1) % 65536;
                if (co) begin
                    m_n0 = edge_idx;
                    m_L = (ex == 0) ? 1 : int'(ex);
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (st && !ab) begin
            m_active = 1'b1;
            m_n0 = edge_idx;
            m_L = (ex == 0) ? 1 : int'(ex);
        end
    endtask

    task automatic model_compare();
        int j;
        int a;
        logic e_expos, e_valid, e_busy;
        logic [2:0] e_addr;
        logic [15:0] e_frame;
        j = edge_idx - m_n0 + 1;
        e_expos = m_active && (j <= m_L);
        e_valid = m_active && (j >= m_L + D + 1) && (j <= m_L + D + P);
        a = e_valid ? (j - (m_L + D + 1)) : 0;
        e_addr = a[2:0];
        e_busy = m_active;
        e_frame = m_frames[15:0];
        check_output($sformatf("model@%0d {expos,valid,addr,complete,busy,frame}", edge_idx),
                     {sensor_expos, data_valid, data_adress, capture_complete, busy, frame_cnt},
                     {e_expos, e_valid, e_addr, m_complete, e_busy, e_frame});
    endtask

    // Drive one clock of inputs, advance past the edge, then compare against the model.
    task automatic apply_stimulus(input logic st, input logic ab, input logic co,
                                  input logic [15:0] ex, input logic rs);
        start_capture = st;
        abort = ab;
        cont_mode = co;
        expos_len = ex;
        rst = rs;
        @(posedge clk_in);
        #1;
        edge_idx++;
        model_edge(st, ab, co, ex, rs);
        model_compare();
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    function automatic vec_t make_vec(input logic st, input logic [15:0] ex, input logic ee,
                                      input logic ev, input int addr, input logic ec,
                                      input logic eb, input int fr);
        vec_t v;
        v.start = st;
        v.expos = ex;
        v.e_expos = ee;
        v.e_valid = ev;
        v.e_addr = ev ? addr[2:0] : 3'd0;
        v.e_complete = ec;
        v.e_busy = eb;
        v.e_frame = fr[15:0];
        return v;
    endfunction

    // Abort the run if something hangs beyond any sensible bound.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int last;
        int s0;
        int r1;
        bit found;
        bit cont_v;
        bit prev;
        int abort_at[4] = '{3, 7, 13, 16};

        // Table: label t is the output seen after the t-th edge counted from the start edge.
        for (int t = 1; t <= 20; t++)
            vecs.push_back(make_vec(t == 1, 16'd5, t <= 5, (t >= 9) && (t <= 16), t - 9,
                                    t == 17, t <= 16, (t >= 17) ? 1 : 0));
        for (int t = 1; t <= 16; t++)
            vecs.push_back(make_vec(t == 1, 16'd0, t == 1, (t >= 5) && (t <= 12), t - 5,
                                    t == 13, t <= 12, (t >= 13) ? 2 : 1));

        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        check_output("reset expos", sensor_expos, 1'b0);
        check_output("reset valid", data_valid, 1'b0);
        check_output("reset addr", data_adress, 3'd0);
        check_output("reset complete", capture_complete, 1'b0);
        check_output("reset busy", busy, 1'b0);
        check_output("reset frame", frame_cnt, 16'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].start, 1'b0, 1'b0, vecs[i].expos, 1'b0);
            check_output($sformatf("tbl[%0d] expos", i), sensor_expos, vecs[i].e_expos);
            check_output($sformatf("tbl[%0d] valid", i), data_valid, vecs[i].e_valid);
            check_output($sformatf("tbl[%0d] addr", i), data_adress, vecs[i].e_addr);
            check_output($sformatf("tbl[%0d] complete", i), capture_complete, vecs[i].e_complete);
            check_output($sformatf("tbl[%0d] busy", i), busy, vecs[i].e_busy);
            check_output($sformatf("tbl[%0d] frame", i), frame_cnt, vecs[i].e_frame);
        end

        // Continuous mode, three frames, cont_mode dropped during the third.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'd4, 1'b0);
        s0 = edge_idx;
        last = s0;
        seen = 0;
        cont_v = 1'b1;
        for (int i = 0; i < 100 && seen < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, cont_v, 16'd4, 1'b0);
            if (capture_complete) begin
                seen++;
                check_output($sformatf("cont period %0d", seen), edge_idx - last, 15);
                check_output($sformatf("cont frame %0d", seen), frame_cnt, seen);
                check_output($sformatf("cont retrigger %0d", seen), sensor_expos, seen < 3);
                check_output($sformatf("cont busy %0d", seen), busy, seen < 3);
                last = edge_idx;
                if (seen == 2) cont_v = 1'b0;
            end
        end
        check_output("cont frames seen", seen, 3);

        // Start held high: no restart mid-frame, new frame right after IDLE.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
        s0 = edge_idx;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
            if (capture_complete) begin
                found = 1'b1;
                check_output("held start frame length", edge_idx - s0, 13);
                check_output("held start busy at end", busy, 1'b0);
            end
        end
        check_output("held start complete seen", found, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
        check_output("held start restart expos", sensor_expos, 1'b1);
        check_output("held start restart busy", busy, 1'b1);
        check_output("held start frame", frame_cnt, 16'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);

        // Aborts in EXPOSE, DELAY, READ at addr 4 and on the last pixel.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
        foreach (abort_at[k]) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
            for (int t = 2; t <= abort_at[k]; t++) apply_stimulus(1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
            if (abort_at[k] == 13) check_output("abort pre addr", data_adress, 3'd4);
            if (abort_at[k] == 16) check_output("abort pre last addr", data_adress, 3'd7);
            apply_stimulus(1'b0, 1'b1, 1'b0, 16'd5, 1'b0);
            check_output($sformatf("abort@%0d outputs", abort_at[k]),
                         {sensor_expos, data_valid, data_adress, capture_complete, busy}, 7'd0);
            check_output($sformatf("abort@%0d frame", abort_at[k]), frame_cnt, 16'd1);
            for (int i = 0; i < 3; i++) begin
                apply_stimulus(1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
                check_output($sformatf("abort@%0d no complete", abort_at[k]), capture_complete, 1'b0);
            end
        end

        // Reset in the middle of readout.
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
        for (int t = 2; t <= 11; t++) apply_stimulus(1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
        check_output("rst pre valid", data_valid, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd5, 1'b1);
        check_output("rst mid-read outputs",
                     {sensor_expos, data_valid, data_adress, capture_complete, busy}, 7'd0);
        check_output("rst mid-read frame", frame_cnt, 16'd0);

        // Randomized traffic, checked every clock by the model.
        do_reset();
        cont_v = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) cont_v = ~cont_v;
            apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, cont_v,
                           16'($urandom_range(0, 6)), $urandom_range(0, 499) == 0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);

        // Default geometry: 50 + 15 + 512 clocks per continuous frame.
        do_reset();
        d_start = 1'b1;
        d_cont = 1'b1;
        d_expos = 16'd50;
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        d_start = 1'b0;
        check_output("def expose start", d_sensor_expos, 1'b1);
        r1 = edge_idx;
        prev = d_sensor_expos;
        found = 1'b0;
        for (int i = 0; i < 1300 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            if (!prev && d_sensor_expos) begin
                found = 1'b1;
                check_output("def cycle length", edge_idx - r1, 577);
                check_output("def complete at retrigger", d_capture_complete, 1'b1);
                d_cont = 1'b0;
            end
            prev = d_sensor_expos;
        end
        check_output("def second frame seen", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            if (!d_busy) found = 1'b1;
        end
        check_output("def returned idle", found, 1'b1);
        check_output("def frame count", d_frame_cnt, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
